// File: rtl/dfr_output_layer.sv
// -----------------------------------------------------------------------------
// dfr_output_layer
//   Linear readout of a delay-feedback reservoir. For every sample s it forms
//   y[s] = sum_n R[s*N+n] * Wt[n] over N virtual nodes and writes y[s] to
//   output address s.
//
//   Memory reads have one cycle of latency. Each product is registered, and
//   then added into a 2W-bit accumulator that wraps on overflow. One sample
//   takes N+3 cycles: N READ cycles, 2 DRAIN cycles and 1 WRITE cycle.
//
//   NUM_VIRTUAL_NODES must be at least 2, so that the weight address has a
//   non-zero width.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               single-cycle launch request (honoured in IDLE only)
//   num_samples         sample count, captured when start is accepted
//   busy, done          run in progress / one-cycle completion pulse
//   reservoir_mem_addr  reservoir read address (s*N+n, wraps modulo 2^A)
//   reservoir_mem_data  reservoir word, valid one cycle after its address
//   weight_mem_addr     weight read address n
//   weight_mem_data     weight word, valid one cycle after its address
//   output_mem_addr     output write address (sample index)
//   output_mem_data     output word y[s]
//   output_mem_wen      output write enable, high only in WRITE
// -----------------------------------------------------------------------------
module dfr_output_layer #(
    parameter int NUM_VIRTUAL_NODES            = 100,
    parameter int RESERVOIR_DATA_WIDTH         = 32,
    parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] num_samples,
    output logic                                   busy,
    output logic                                   done,
    output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] reservoir_mem_addr,
    input  logic [RESERVOIR_DATA_WIDTH-1:0]         reservoir_mem_data,
    output logic [$clog2(NUM_VIRTUAL_NODES)-1:0]    weight_mem_addr,
    input  logic [RESERVOIR_DATA_WIDTH-1:0]         weight_mem_data,
    output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] output_mem_addr,
    output logic [RESERVOIR_DATA_WIDTH-1:0]         output_mem_data,
    output logic                                   output_mem_wen
);
    localparam int W  = RESERVOIR_DATA_WIDTH;
    localparam int A  = RESERVOIR_HISTORY_ADDR_WIDTH;
    localparam int NW = $clog2(NUM_VIRTUAL_NODES);
    localparam logic [NW-1:0] LAST_NODE = NW'(NUM_VIRTUAL_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // Full-precision signed product of two W-bit words.
    function automatic logic signed [2*W-1:0] mul_full(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [2*W-1:0] ax;
        logic signed [2*W-1:0] bx;
        ax = {{W{a[W-1]}}, a};
        bx = {{W{b[W-1]}}, b};
        return ax * bx;
    endfunction

    // The output word is the wrapped low half of the accumulator.
    function automatic logic [W-1:0] low_word(input logic signed [2*W-1:0] v);
        return v[W-1:0];
    endfunction

    state_t                 state_q;
    logic [A-1:0]           nsamp_q;
    logic [A-1:0]           sample_q;
    logic [NW-1:0]          node_q;
    logic [A-1:0]           raddr_q;
    logic                   drain_q;
    logic signed [2*W-1:0]  acc_q;
    logic signed [2*W-1:0]  acc_d;
    logic [W-1:0]           out_data_q;
    logic                   wen_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   vld_p1_q;   // memory data valid this cycle
    logic                   vld_p2_q;   // registered product valid this cycle
    logic signed [2*W-1:0]  prod_p2_q;

    assign acc_d = vld_p2_q ? (acc_q + prod_p2_q) : acc_q;

    // ---- stage p1 -> p2: register the product of the returned words ----
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            prod_p2_q <= mul_full(reservoir_mem_data, weight_mem_data);
        end
    end

    // ---- stage p2 -> accumulator, and sequencing control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nsamp_q    <= '0;
            sample_q   <= '0;
            node_q     <= '0;
            raddr_q    <= '0;
            drain_q    <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            wen_q    <= 1'b0;
            done_q   <= 1'b0;
            vld_p1_q <= (state_q == S_READ);
            vld_p2_q <= vld_p1_q;
            acc_q    <= acc_d;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nsamp_q  <= num_samples;
                        sample_q <= '0;
                        node_q   <= '0;
                        raddr_q  <= '0;
                        acc_q    <= '0;
                        if (num_samples == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    raddr_q <= raddr_q + A'(1);
                    if (node_q == LAST_NODE) begin
                        node_q  <= '0;
                        drain_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        node_q <= node_q + NW'(1);
                    end
                end
                S_DRAIN: begin
                    // The last product lands in the accumulator on the second
                    // DRAIN edge, so the output word is taken from acc_d here.
                    if (drain_q) begin
                        out_data_q <= low_word(acc_d);
                        wen_q      <= 1'b1;
                        state_q    <= S_WRITE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    acc_q    <= '0;
                    sample_q <= sample_q + A'(1);
                    if (sample_q == nsamp_q - A'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign reservoir_mem_addr = raddr_q;
    assign weight_mem_addr    = node_q;
    assign output_mem_addr    = sample_q;
    assign output_mem_data    = out_data_q;
    assign output_mem_wen     = wen_q;

endmodule

// File: tb/tb_dfr_output_layer.sv
module tb_dfr_output_layer;
    localparam int N = 100;
    localparam int W = 32;
    localparam int A = 16;
    localparam int P = N + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [A-1:0]  num_samples;
    logic          busy;
    logic          done;
    logic [A-1:0]  res_addr;
    logic [W-1:0]  res_rd;
    logic [6:0]    wt_addr;
    logic [W-1:0]  wt_rd;
    logic [A-1:0]  out_addr;
    logic [W-1:0]  out_data;
    logic          out_wen;

    dfr_output_layer #(
        .NUM_VIRTUAL_NODES(N),
        .RESERVOIR_DATA_WIDTH(W),
        .RESERVOIR_HISTORY_ADDR_WIDTH(A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_samples(num_samples),
        .busy(busy),
        .done(done),
        .reservoir_mem_addr(res_addr),
        .reservoir_mem_data(res_rd),
        .weight_mem_addr(wt_addr),
        .weight_mem_data(wt_rd),
        .output_mem_addr(out_addr),
        .output_mem_data(out_data),
        .output_mem_wen(out_wen)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency.
    logic [W-1:0] res_mem [0:65535];
    logic [W-1:0] wt_mem  [0:127];
    always @(posedge clk) begin
        res_rd <= res_mem[res_addr];
        wt_rd  <= wt_mem[wt_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation queues, filled on the falling edge.
    int           wr_addr[$];
    logic [W-1:0] wr_data[$];
    int           wr_cyc[$];
    int           done_cyc[$];
    int           busy_cyc[$];
    int           overlap[$];
    always @(negedge clk) begin
        if (out_wen) begin
            wr_addr.push_back(int'(out_addr));
            wr_data.push_back(out_data);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_cyc.push_back(cyc);
        if (done && busy) overlap.push_back(cyc);
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_y(input int s);
        longint acc;
        acc = 0;
        for (int n = 0; n < N; n++)
            acc += longint'($signed(res_mem[(s * N + n) % 65536])) * longint'($signed(wt_mem[n]));
        return acc[W-1:0];
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < 1024; i++) begin
            case (mode)
                0, 1:    res_mem[i] = W'(i);
                2:       res_mem[i] = 32'h7FFF_FFFF;
                default: res_mem[i] = $urandom;
            endcase
        end
        for (int n = 0; n < 128; n++) begin
            case (mode)
                0:       wt_mem[n] = 32'h0000_0001;
                1:       wt_mem[n] = 32'hFFFF_FFFF;
                2:       wt_mem[n] = 32'h7FFF_FFFF;
                default: wt_mem[n] = $urandom;
            endcase
        end
    endtask

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        busy_cyc.delete();
        overlap.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wen"}, out_wen, 0);
        chk({tag, "_raddr"}, res_addr, 0);
        chk({tag, "_waddr"}, wt_addr, 0);
        chk({tag, "_oaddr"}, out_addr, 0);
        chk({tag, "_odata"}, out_data, 0);
    endtask

    // One complete run; optionally disturbs start/num_samples mid-run.
    task automatic do_run(input int S, input bit disturb);
        int c0;
        clear_obs();
        @(negedge clk);
        start       = 1'b1;
        num_samples = A'(S);
        c0          = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < S * P + 20 && done_cyc.size() == 0; k++) begin
            if (disturb) begin
                num_samples = A'($urandom_range(1, 9));
                start       = (k == 40 || k == P + 7);
            end
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0)
            chk("done_latency", done_cyc[0] - c0, S * P + 1);
        chk("busy_cycles", busy_cyc.size(), S * P);
        if (S > 0 && busy_cyc.size() > 0) begin
            chk("busy_rise", busy_cyc[0] - c0, 1);
            if (done_cyc.size() > 0)
                chk("busy_to_done", done_cyc[0] - busy_cyc[0], S * P);
        end
        chk("busy_at_done", overlap.size(), 0);
        chk("write_count", wr_addr.size(), S);
        for (int s = 0; s < S && s < wr_addr.size(); s++) begin
            chk("wr_addr", wr_addr[s], s);
            chk("wr_data", wr_data[s], ref_y(s));
            chk("wr_time", wr_cyc[s] - c0, (s + 1) * P);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        for (int i = 0; i < 65536; i++) res_mem[i] = '0;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        fill(0);
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Ramp reservoir, unit weights.
        do_run(5, 1'b0);
        for (int s = 0; s < 5 && s < wr_data.size(); s++)
            chk("ramp_const", wr_data[s], 4950 + 10000 * s);

        // Negative weights.
        fill(1);
        do_run(1, 1'b0);
        if (wr_data.size() > 0) chk("neg_const", wr_data[0], 32'hFFFF_ECAA);

        // Accumulator wrap.
        fill(2);
        do_run(1, 1'b0);
        if (wr_data.size() > 0) chk("wrap_const", wr_data[0], 100);

        // Zero-sample run.
        do_run(0, 1'b0);

        // Random data, disturbed start/num_samples.
        fill(3);
        do_run(3, 1'b1);
        for (int t = 0; t < 2; t++) begin
            fill(3);
            do_run($urandom_range(1, 4), 1'b0);
        end

        // Reset during sample 2 of a 5-sample run.
        fill(0);
        clear_obs();
        @(negedge clk);
        start       = 1'b1;
        num_samples = A'(5);
        c0          = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3 * P && cyc < c0 + 2 * P + 40; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (6 * P) @(negedge clk);
        #1;
        chk("abort_writes", wr_addr.size(), 2);
        chk("abort_done", done_cyc.size(), 0);

        // Reset wins over start in the same cycle.
        clear_obs();
        @(negedge clk);
        rst         = 1'b1;
        start       = 1'b1;
        num_samples = A'(3);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("rst_prio_busy", busy_cyc.size(), 0);
        chk("rst_prio_writes", wr_addr.size(), 0);

        // Fresh run after the abort.
        do_run(5, 1'b0);
        for (int s = 0; s < 5 && s < wr_data.size(); s++)
            chk("rerun_const", wr_data[s], 4950 + 10000 * s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
